fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the decoder/control block. Holds the PC, issues

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response side plus decode handshake.
// The fetch unit takes the master view, the memory/decode environment the slave view.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, id_opcode, id_funct3, id_funct7,
        input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_opcode, id_funct3, id_funct7,
        output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order imem reads, BUF_DEPTH-entry buffer, redirect drain.
// Optional FETCH_BYPASS_EN: a response landing on an empty buffer goes straight to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.master bus
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t        state, state_nx;
    logic [31:0]   fetch_pc, resp_pc;
    logic [31:0]   buf_instr [BUF_DEPTH];
    logic [31:0]   buf_pc    [BUF_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, outst, discard, out_nx;
    logic [CW:0]   occ;
    logic          hs, redir, rsp_run, byp, wr, pop_buf;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        redir   = bus.redirect_valid;
        rsp_run = bus.imem_rvalid && (state == RUN) && !redir;
        pop_buf = (count != '0) && bus.id_ready && !redir;
`ifdef FETCH_BYPASS_EN
        byp     = rsp_run && (count == '0);
`else
        byp     = 1'b0;
`endif
        // A bypassed word that decode takes immediately never occupies a slot.
        wr      = rsp_run && !(byp && bus.id_ready);
        // Slot freed by this cycle's pop is reusable, keeping 1 instr/cycle at BUF_DEPTH=2.
        occ     = {1'b0, count} + {1'b0, outst} - (CW+1)'(pop_buf);
        bus.imem_req  = !rst && (state == RUN) && !redir && (occ < DEPTH_W);
        bus.imem_addr = fetch_pc;
        hs      = bus.imem_req && bus.imem_ready;
        out_nx  = outst + CW'(hs) - CW'(bus.imem_rvalid);
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:   if (redir && out_nx != '0) state_nx = DRAIN;
            DRAIN: begin
                if (redir)
                    state_nx = (out_nx != '0) ? DRAIN : RUN;
                else if (bus.imem_rvalid && discard == CW'(1))
                    state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        bus.id_valid = 1'b0;
        bus.id_instr = NOP;
        bus.id_pc    = resp_pc;
        if (count != '0) begin
            bus.id_valid = 1'b1;
            bus.id_instr = buf_instr[head];
            bus.id_pc    = buf_pc[head];
        end
`ifdef FETCH_BYPASS_EN
        if (byp) begin
            bus.id_valid = 1'b1;
            bus.id_instr = bus.imem_rdata;
            bus.id_pc    = resp_pc;
        end
`endif
        bus.id_opcode = bus.id_instr[6:0];
        bus.id_funct3 = bus.id_instr[14:12];
        bus.id_funct7 = bus.id_instr[31:25];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            outst    <= '0;
            discard  <= '0;
        end else begin
            state <= state_nx;
            outst <= out_nx;
            if (redir) begin
                // Everything still in flight (including a same-cycle response) is stale.
                fetch_pc <= bus.redirect_pc & ~32'h3;
                resp_pc  <= bus.redirect_pc & ~32'h3;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                discard  <= out_nx;
            end else begin
                if (hs) fetch_pc <= fetch_pc + 32'd4;
                if (rsp_run) resp_pc <= resp_pc + 32'd4;
                if (state == DRAIN && bus.imem_rvalid) discard <= discard - CW'(1);
                if (wr) tail <= ptr_inc(tail);
                if (pop_buf) head <= ptr_inc(head);
                count <= count + CW'(wr) - CW'(pop_buf);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            buf_instr[tail] <= bus.imem_rdata;
            buf_pc[tail]    <= resp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level memory model plus an in-order
// stream scoreboard (expected PC sequence, epochs for redirects), directed and random phases.
module tb_fetch_unit;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          DEPTH = 2;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_LAT = 1;
`else
    localparam int FIRST_LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus();
    fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { int cyc; logic [31:0] pc; } pop_t;

    req_t  pend[$];
    pop_t  pop_log[$];
    int    errs = 0, checks = 0;
    int    cyc = 0, epoch = 0, lat = 1, rdy_pct = 100, rv_pct = 100, n_hs = 0;
    logic  s_req, s_idv, s_rv;
    logic [31:0] s_addr, s_pc, s_instr, exp_addr, exp_pc;
    logic [6:0]  s_op;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h0020_8033;
        return (a * 32'h9E37_79B1) ^ {a[15:0], 16'h0013};
    endfunction

    // One clock: drive inputs, sample outputs, then advance the reference model.
    task automatic step(input logic r, input logic idr, input logic redir, input logic [31:0] rpc);
        logic stale, hs, pop;
        logic [31:0] w;
        @(posedge clk);
        #1;
        cyc++;
        rst = r;
        bus.id_ready       = idr;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_ready     = ($urandom_range(99) < rdy_pct);
        s_rv = !r && pend.size() > 0 && pend[0].due <= cyc && ($urandom_range(99) < rv_pct);
        bus.imem_rvalid = s_rv;
        bus.imem_rdata  = s_rv ? mem_word(pend[0].addr) : $urandom;
        #1;
        s_req = bus.imem_req;  s_addr = bus.imem_addr; s_idv = bus.id_valid;
        s_pc  = bus.id_pc;     s_instr = bus.id_instr; s_op = bus.id_opcode;
        if (r) begin
            pend.delete(); pop_log.delete();
            exp_addr = RPC; exp_pc = RPC; n_hs = 0;
            return;
        end
        stale = 1'b0;
        foreach (pend[i]) if (pend[i].epoch != epoch) stale = 1'b1;
        if (stale) chk("req_during_drain", {31'b0, s_req}, 32'd0);
        if (s_req) chk("imem_addr", s_addr, exp_addr);
        if (s_idv && !redir) begin
            w = mem_word(exp_pc);
            chk("id_pc", s_pc, exp_pc);
            chk("id_instr", s_instr, w);
            chk("id_opcode", {25'b0, s_op}, {25'b0, w[6:0]});
            chk("id_funct3", {29'b0, bus.id_funct3}, {29'b0, w[14:12]});
            chk("id_funct7", {25'b0, bus.id_funct7}, {25'b0, w[31:25]});
        end
        hs  = s_req && bus.imem_ready;
        pop = s_idv && idr && !redir;
        if (pop) begin
            pop_log.push_back('{cyc, s_pc});
            exp_pc += 32'd4;
        end
        if (hs) begin
            pend.push_back('{s_addr, epoch, cyc + lat});
            exp_addr += 32'd4;
            n_hs++;
        end
        if (s_rv) void'(pend.pop_front());
        if (redir) begin
            epoch++;
            exp_addr = rpc & ~32'h3;
            exp_pc   = rpc & ~32'h3;
        end
        chk("outstanding_bound", {31'b0, pend.size() <= DEPTH}, 32'd1);
    endtask

    task automatic do_reset();
        lat = 1; rdy_pct = 100; rv_pct = 100;
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic run_until_pop(input int budget);
        for (int i = 0; i < budget && pop_log.size() == 0; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        int rel;
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;

        // Reset state and first request
        do_reset();
        chk("rst_req", {31'b0, s_req}, 32'd0);
        chk("rst_addr", s_addr, RPC);
        chk("rst_id_valid", {31'b0, s_idv}, 32'd0);
        chk("rst_id_instr", s_instr, 32'h0000_0013);
        chk("rst_id_pc", s_pc, RPC);
        rel = cyc + 1;
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("first_req", {31'b0, s_req}, 32'd1);
        chk("first_addr", s_addr, RPC);
        chk("first_id_valid", {31'b0, s_idv}, 32'd0);

        // Zero-wait streaming: one instruction per cycle
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("stream_pops", {31'b0, pop_log.size() >= 4}, 32'd1);
        if (pop_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("stream_pc", pop_log[i].pc, RPC + 32'(4 * i));
            chk("stream_first_lat", 32'(pop_log[0].cyc - rel), 32'(FIRST_LAT));
            chk("stream_back_to_back", 32'(pop_log[3].cyc - pop_log[0].cyc), 32'd3);
        end

        // Backpressure: buffer full stops requests
        do_reset();
        repeat (8) step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("bp_handshakes", 32'(n_hs), 32'(DEPTH));
        chk("bp_req_low", {31'b0, s_req}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("bp_head_valid", {31'b0, s_idv}, 32'd1);
        chk("bp_head_pc", s_pc, RPC);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("bp_req_resume", {31'b0, s_req}, 32'd1);

        // Redirect with two reads in flight
        do_reset();
        lat = 4;
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("redir_inflight", 32'(pend.size()), 32'd2);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0102);
        lat = 1;
        repeat (3) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk("drain_req_low", {31'b0, s_req}, 32'd0);
            chk("drain_id_valid", {31'b0, s_idv}, 32'd0);
        end
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("drain_req_resume", {31'b0, s_req}, 32'd1);
        chk("drain_new_addr", s_addr, 32'h0000_0100);
        pop_log.delete();
        run_until_pop(10);
        chk("drain_got_pop", {31'b0, pop_log.size() > 0}, 32'd1);
        if (pop_log.size() > 0) chk("drain_first_pc", pop_log[0].pc, 32'h0000_0100);

        // Redirect coinciding with pop and rvalid
        do_reset();
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0300);
        chk("coinc_rvalid", {31'b0, s_rv}, 32'd1);
        chk("coinc_id_valid", {31'b0, s_idv}, 32'd1);
        pop_log.delete();
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("coinc_next_id_valid", {31'b0, s_idv}, 32'd0);
        chk("coinc_next_addr", s_addr, 32'h0000_0300);
        run_until_pop(10);
        chk("coinc_got_pop", {31'b0, pop_log.size() > 0}, 32'd1);
        if (pop_log.size() > 0) chk("coinc_first_pc", pop_log[0].pc, 32'h0000_0300);

        // Response-to-decode latency on an empty buffer
        do_reset();
        rdy_pct = 0;
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        rdy_pct = 100;
        step(1'b0, 1'b1, 1'b0, 32'h0);
        rdy_pct = 0;
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("lat_rvalid", {31'b0, s_rv}, 32'd1);
`ifdef FETCH_BYPASS_EN
        chk("lat_id_valid_same", {31'b0, s_idv}, 32'd1);
        chk("lat_opcode_same", {25'b0, s_op}, 32'h33);
`else
        chk("lat_id_valid_same", {31'b0, s_idv}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("lat_id_valid_next", {31'b0, s_idv}, 32'd1);
        chk("lat_opcode_next", {25'b0, s_op}, 32'h33);
`endif

        // Random traffic against the scoreboard, including the 32-bit PC wrap
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            if (i % 50 == 0) begin
                lat     = $urandom_range(1, 4);
                rdy_pct = $urandom_range(30, 100);
                rv_pct  = $urandom_range(30, 100);
            end
            tgt = ($urandom_range(2) == 0) ? 32'hFFFF_FFF6 : ($urandom & 32'h0000_FFFF);
            if (i == 1500 || i == 1501)
                step(1'b1, 1'b1, 1'b0, 32'h0);
            else
                step(1'b0, $urandom_range(99) < 70, $urandom_range(99) < 4, tgt);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
